vpopc_seq: RTL and testbench

VPOPC_SEQ -- requirements
Module: vpopc_seq

---
 rtl/vpopc_pkg.sv | 22 ++
 rtl/vpopc_tail_mask.sv | 25 ++
 rtl/vpopc_seq.sv | 175 +++++++++++++++++
 tb/tb_vpopc_seq.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpopc_pkg.sv
// Shared definitions for the mask-popcount sequencer: FSM states, default
// widths and SEW encodings.
package vpopc_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_SEW_WIDTH  = 2;
    localparam int DEF_VL_WIDTH   = 16;

    localparam logic [1:0] SEW_8  = 2'd0;
    localparam logic [1:0] SEW_16 = 2'd1;
    localparam logic [1:0] SEW_32 = 2'd2;
    localparam logic [1:0] SEW_64 = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP
    } state_t;

endpackage

// File: rtl/vpopc_tail_mask.sv
// Clears the element bits (positions j<<sew) whose element index j is at or
// beyond r; non-element bits and elements below r pass through untouched.
module vpopc_tail_mask
    import vpopc_pkg::*;
#(
    parameter int MASK_W    = DEF_DATA_WIDTH / 8,
    parameter int SEW_WIDTH = DEF_SEW_WIDTH,
    parameter int R_WIDTH   = DEF_VL_WIDTH + 1
) (
    input  logic [SEW_WIDTH-1:0] sew,
    input  logic [R_WIDTH-1:0]   r,
    input  logic [MASK_W-1:0]    raw,
    output logic [MASK_W-1:0]    masked
);

    always_comb begin
        masked = raw;
        for (int b = 0; b < MASK_W; b++) begin
            if (((b & ((1 << sew) - 1)) == 0) && ((b >> sew) >= int'(r))) begin
                masked[b] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vpopc_seq.sv
// Sequencer for a vector mask popcount: streams mask beats from memory into
// the popcount datapath and returns the datapath's total as a result.
module vpopc_seq
    import vpopc_pkg::*;
#(
    parameter int REQ_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int REQ_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SEW_WIDTH      = DEF_SEW_WIDTH,
    parameter int VL_WIDTH       = DEF_VL_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [VL_WIDTH-1:0]         cmd_vl,
    input  logic [SEW_WIDTH-1:0]        cmd_sew,
    input  logic [REQ_ADDR_WIDTH-1:0]   cmd_src_addr,
    input  logic [REQ_ADDR_WIDTH-1:0]   cmd_dst_addr,
    output logic                        rd_en,
    output logic [REQ_ADDR_WIDTH-1:0]   rd_addr,
    input  logic [REQ_DATA_WIDTH/8-1:0] rd_data,
    output logic                        dp_valid,
    output logic                        dp_start,
    output logic                        dp_end,
    output logic [REQ_DATA_WIDTH/8-1:0] dp_m0,
    output logic [SEW_WIDTH-1:0]        dp_sew,
    output logic [REQ_ADDR_WIDTH-1:0]   dp_addr,
    input  logic                        dp_out_valid,
    input  logic [REQ_DATA_WIDTH-1:0]   dp_out_vec,
    input  logic [REQ_ADDR_WIDTH-1:0]   dp_out_addr,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [REQ_DATA_WIDTH-1:0]   res_data,
    output logic [REQ_ADDR_WIDTH-1:0]   res_addr
);

    localparam int MASK_W  = REQ_DATA_WIDTH / 8;
    localparam int LOG2_MW = $clog2(MASK_W);
    localparam int CNT_W   = VL_WIDTH + 1;

    localparam logic [SEW_WIDTH:0]      LOG2_W   = (SEW_WIDTH + 1)'(LOG2_MW);
    localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
    localparam logic [REQ_ADDR_WIDTH-1:0] ADDR_ONE = REQ_ADDR_WIDTH'(1);

    state_t                    state;
    logic [SEW_WIDTH-1:0]      sew_q;
    logic [REQ_ADDR_WIDTH-1:0] dst_q;
    logic [CNT_W-1:0]          n_beats;
    logic [CNT_W-1:0]          beat_cnt;
    logic [CNT_W-1:0]          r_last;
    logic                      rd_first;
    logic                      rd_last;

    logic [CNT_W-1:0]          vl_ext;
    logic [SEW_WIDTH:0]        shift;
    logic [CNT_W-1:0]          elems;
    logic [CNT_W-1:0]          n_calc;
    logic [CNT_W-1:0]          r_calc;
    logic [CNT_W-1:0]          r_sel;
    logic [MASK_W-1:0]         m0_masked;

    // Elements per beat is a power of two, so ceil-divide and the tail
    // remainder reduce to shifts.
    always_comb begin
        vl_ext = {1'b0, cmd_vl};
        shift  = LOG2_W - {1'b0, cmd_sew};
        elems  = CNT_ONE << shift;
        n_calc = (vl_ext + elems - CNT_ONE) >> shift;
        r_calc = vl_ext - ((n_calc - CNT_ONE) << shift);
    end

    assign cmd_ready = (state == IDLE);

    // Non-final beats get an out-of-range r so nothing is cleared.
    assign r_sel = dp_end ? r_last : '1;

    vpopc_tail_mask #(
        .MASK_W    (MASK_W),
        .SEW_WIDTH (SEW_WIDTH),
        .R_WIDTH   (CNT_W)
    ) u_tail_mask (
        .sew    (sew_q),
        .r      (r_sel),
        .raw    (rd_data),
        .masked (m0_masked)
    );

    assign dp_m0 = dp_valid ? m0_masked : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sew_q     <= '0;
            dst_q     <= '0;
            n_beats   <= '0;
            beat_cnt  <= '0;
            r_last    <= '0;
            rd_first  <= 1'b0;
            rd_last   <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            dp_valid  <= 1'b0;
            dp_start  <= 1'b0;
            dp_end    <= 1'b0;
            dp_sew    <= '0;
            dp_addr   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_addr  <= '0;
        end else begin
            // Read data arrives one cycle after rd_en, so the beat strobes trail it.
            dp_valid <= rd_en;
            dp_start <= rd_en & rd_first;
            dp_end   <= rd_en & rd_last;
            dp_sew   <= rd_en ? sew_q : '0;
            dp_addr  <= rd_en ? dst_q : '0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        sew_q   <= cmd_sew;
                        dst_q   <= cmd_dst_addr;
                        n_beats <= n_calc;
                        r_last  <= r_calc;
                        if (cmd_vl == '0) begin
                            res_valid <= 1'b1;
                            res_data  <= '0;
                            res_addr  <= cmd_dst_addr;
                            state     <= RESP;
                        end else begin
                            rd_en    <= 1'b1;
                            rd_addr  <= cmd_src_addr;
                            rd_first <= 1'b1;
                            rd_last  <= (n_calc == CNT_ONE);
                            beat_cnt <= CNT_ONE;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (beat_cnt == n_beats) begin
                        rd_en    <= 1'b0;
                        rd_addr  <= '0;
                        rd_first <= 1'b0;
                        rd_last  <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        rd_addr  <= rd_addr + ADDR_ONE;
                        rd_first <= 1'b0;
                        rd_last  <= ((beat_cnt + CNT_ONE) == n_beats);
                        beat_cnt <= beat_cnt + CNT_ONE;
                    end
                end
                DRAIN: begin
                    if (dp_out_valid) begin
                        res_valid <= 1'b1;
                        res_data  <= dp_out_vec;
                        res_addr  <= dp_out_addr;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_data  <= '0;
                        res_addr  <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vpopc_seq.sv
// Self-checking bench for vpopc_seq: memory and popcount-datapath responders,
// an element-level reference model and a per-cycle output comparator.
module tb_vpopc_seq;
    import vpopc_pkg::*;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int SW = 2;
    localparam int VW = 16;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [VW-1:0] cmd_vl = '0;
    logic [SW-1:0] cmd_sew = '0;
    logic [AW-1:0] cmd_src_addr = '0;
    logic [AW-1:0] cmd_dst_addr = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [MW-1:0] rd_data = '0;
    logic          dp_valid, dp_start, dp_end;
    logic [MW-1:0] dp_m0;
    logic [SW-1:0] dp_sew;
    logic [AW-1:0] dp_addr;
    logic          dp_out_valid = 1'b0;
    logic [DW-1:0] dp_out_vec = '0;
    logic [AW-1:0] dp_out_addr = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_data;
    logic [AW-1:0] res_addr;

    always #5 clk = ~clk;

    vpopc_seq #(
        .REQ_DATA_WIDTH (DW),
        .REQ_ADDR_WIDTH (AW),
        .SEW_WIDTH      (SW),
        .VL_WIDTH       (VW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_vl       (cmd_vl),
        .cmd_sew      (cmd_sew),
        .cmd_src_addr (cmd_src_addr),
        .cmd_dst_addr (cmd_dst_addr),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .dp_valid     (dp_valid),
        .dp_start     (dp_start),
        .dp_end       (dp_end),
        .dp_m0        (dp_m0),
        .dp_sew       (dp_sew),
        .dp_addr      (dp_addr),
        .dp_out_valid (dp_out_valid),
        .dp_out_vec   (dp_out_vec),
        .dp_out_addr  (dp_out_addr),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_addr     (res_addr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mask memory: beat i of the current command holds pat[i].
    logic [7:0]    pat [64];
    logic [AW-1:0] cur_src = '0;

    always @(posedge clk) begin
        rd_data <= rd_en ? pat[6'(rd_addr - cur_src)] : 8'($urandom);
    end

    // Popcount datapath: counts element bits and answers 6 cycles after dp_end.
    bit            spur = 1'b0;
    int            tmr = 0;
    logic [63:0]   acc = '0;
    logic [63:0]   out_sum = '0;
    logic [AW-1:0] out_addr = '0;
    logic [63:0]   dp_nxt;

    function automatic int elem_bits(input logic [7:0] m, input logic [1:0] s);
        int c = 0;
        for (int j = 0; j < (8 >> s); j++) c += int'(m[j << s]);
        return c;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            tmr          <= 0;
            acc          <= '0;
            dp_out_valid <= 1'b0;
        end else begin
            dp_out_valid <= 1'b0;
            if (dp_valid) begin
                dp_nxt = (dp_start ? 64'd0 : acc) + 64'(elem_bits(dp_m0, dp_sew));
                acc <= dp_nxt;
                if (dp_end) begin
                    tmr      <= 5;
                    out_sum  <= dp_nxt;
                    out_addr <= dp_addr;
                end
            end
            if (tmr == 1) begin
                dp_out_valid <= 1'b1;
                dp_out_vec   <= out_sum;
                dp_out_addr  <= out_addr;
                tmr          <= 0;
            end else if (tmr > 1) begin
                tmr <= tmr - 1;
            end
            if (spur) begin
                dp_out_valid <= 1'b1;
                dp_out_vec   <= {$urandom, $urandom};
                dp_out_addr  <= $urandom;
            end
        end
    end

    // Reference model: per-command expectations derived element by element.
    bit            m_active = 1'b0;
    int            m_o = 0, m_n = 0, m_resp_o = 0, m_vl = 0, m_e = 0;
    logic [1:0]    m_sew = '0;
    logic [AW-1:0] m_src = '0, m_dst = '0;
    logic [7:0]    m_exp_m0 [64];
    logic [7:0]    m_beat;
    logic [63:0]   m_result = '0;
    int            mon_rd = 0;
    logic [7:0]    mon_last_m0 = '0;

    always @(posedge clk) begin
        if (rd_en) mon_rd++;
        if (dp_valid && dp_end) mon_last_m0 = dp_m0;
        if (rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (cmd_valid) begin
                m_active = 1'b1;
                m_o      = 1;
                m_vl     = int'(cmd_vl);
                m_sew    = cmd_sew;
                m_src    = cmd_src_addr;
                m_dst    = cmd_dst_addr;
                m_e      = 8 >> m_sew;
                m_n      = (m_vl + m_e - 1) / m_e;
                m_result = '0;
                for (int i = 0; i < m_n; i++) begin
                    m_beat = pat[i];
                    for (int j = 0; j < m_e; j++) begin
                        if (i * m_e + j < m_vl) m_result += 64'(m_beat[j << m_sew]);
                        else m_beat[j << m_sew] = 1'b0;
                    end
                    m_exp_m0[i] = m_beat;
                end
                m_resp_o    = (m_vl == 0) ? 1 : m_n + 8;
                mon_rd      = 0;
                mon_last_m0 = '0;
            end
        end else if (m_o >= m_resp_o && res_ready) begin
            m_active = 1'b0;
        end else begin
            m_o++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    bit cmp_on = 1'b0;
    bit e_rd, e_dp, e_res;

    always @(negedge clk) begin
        if (cmp_on) begin
            e_rd  = m_active && m_o >= 1 && m_o <= m_n;
            e_dp  = m_active && m_o >= 2 && m_o <= m_n + 1;
            e_res = m_active && m_o >= m_resp_o;
            checkOutput("cmd_ready", cmd_ready, !m_active);
            checkOutput("rd_en", rd_en, e_rd);
            if (e_rd) checkOutput("rd_addr", rd_addr, m_src + AW'(m_o - 1));
            checkOutput("dp_valid", dp_valid, e_dp);
            checkOutput("dp_start", dp_start, e_dp && m_o == 2);
            checkOutput("dp_end", dp_end, e_dp && m_o == m_n + 1);
            checkOutput("dp_m0", dp_m0, e_dp ? m_exp_m0[m_o - 2] : 8'h00);
            if (e_dp) begin
                checkOutput("dp_sew", dp_sew, m_sew);
                checkOutput("dp_addr", dp_addr, m_dst);
            end
            checkOutput("res_valid", res_valid, e_res);
            if (e_res) begin
                checkOutput("res_data", res_data, m_result);
                checkOutput("res_addr", res_addr, m_dst);
            end
        end
    end

    task automatic applyStimulus(input int vl, input int sew, input logic [AW-1:0] src,
                                 input logic [AW-1:0] dst);
        int waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) checkOutput("cmd_ready_timeout", 64'd0, 64'd1);
        cur_src      = src;
        cmd_vl       = VW'(vl);
        cmd_sew      = SW'(sew);
        cmd_src_addr = src;
        cmd_dst_addr = dst;
        cmd_valid    = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic awaitResult(input int hold, output logic [63:0] data);
        int waited = 0;
        data = '0;
        while (!res_valid && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!res_valid) begin
            checkOutput("res_valid_timeout", 64'd0, 64'd1);
            return;
        end
        data = res_data;
        for (int h = 0; h < hold; h++) begin
            spur = (h == 1);
            @(negedge clk);
        end
        spur      = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic fillPattern(input logic [7:0] v);
        for (int i = 0; i < 64; i++) pat[i] = v;
    endtask

    logic [63:0] r;
    int          waited;

    initial begin
        fillPattern(8'hFF);
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        cmp_on = 1'b1;
        @(negedge clk);
        checkOutput("reset_cmd_ready", cmd_ready, 1);
        checkOutput("reset_rd_en", rd_en, 0);
        checkOutput("reset_res_valid", res_valid, 0);

        // Single full beat.
        applyStimulus(8, 0, 32'h1000, 32'hA000);
        awaitResult(0, r);
        checkOutput("vl8_result", r, 8);
        checkOutput("vl8_model", m_result, 8);
        checkOutput("vl8_last_m0", mon_last_m0, 8'hFF);
        checkOutput("vl8_rd_pulses", mon_rd, 1);

        // Three beats with a four-element tail.
        applyStimulus(20, 0, 32'h2000, 32'hB000);
        awaitResult(2, r);
        checkOutput("vl20_result", r, 20);
        checkOutput("vl20_last_m0", mon_last_m0, 8'h0F);
        checkOutput("vl20_rd_pulses", mon_rd, 3);

        // At sew=1 only even bits are elements; odd bits pass through untouched.
        applyStimulus(5, 1, 32'h3000, 32'hC000);
        awaitResult(0, r);
        checkOutput("sew16_result", r, 5);
        checkOutput("sew16_last_m0", mon_last_m0, 8'hAB);
        checkOutput("sew16_rd_pulses", mon_rd, 2);

        // Empty vector answers immediately.
        applyStimulus(0, 2, 32'h4000, 32'hD000);
        checkOutput("vl0_res_valid_next", res_valid, 1);
        checkOutput("vl0_res_addr", res_addr, 32'hD000);
        awaitResult(0, r);
        checkOutput("vl0_result", r, 0);
        checkOutput("vl0_rd_pulses", mon_rd, 0);

        // Stalled result with the next command already waiting.
        applyStimulus(8, 0, 32'h5000, 32'hE000);
        waited = 0;
        while (!res_valid && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        for (int h = 0; h < 10; h++) begin
            checkOutput("stall_res_valid", res_valid, 1);
            checkOutput("stall_res_data", res_data, 8);
            checkOutput("stall_cmd_ready", cmd_ready, 0);
            if (h == 5) begin
                cur_src      = 32'h6000;
                cmd_vl       = 16'd20;
                cmd_sew      = 2'd0;
                cmd_src_addr = 32'h6000;
                cmd_dst_addr = 32'hF000;
                cmd_valid    = 1'b1;
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("after_hs_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("second_cmd_rd_en", rd_en, 1);
        awaitResult(0, r);
        checkOutput("second_cmd_result", r, 20);
        checkOutput("second_cmd_rd_pulses", mon_rd, 3);

        // Reset on the second ISSUE cycle aborts the command.
        applyStimulus(20, 0, 32'h7000, 32'h8000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_cmd_ready", cmd_ready, 1);
        checkOutput("abort_rd_en", rd_en, 0);
        checkOutput("abort_rd_addr", rd_addr, 0);
        checkOutput("abort_dp_valid", dp_valid, 0);
        checkOutput("abort_dp_start", dp_start, 0);
        checkOutput("abort_dp_end", dp_end, 0);
        checkOutput("abort_dp_m0", dp_m0, 0);
        checkOutput("abort_dp_sew", dp_sew, 0);
        checkOutput("abort_dp_addr", dp_addr, 0);
        checkOutput("abort_res_valid", res_valid, 0);
        checkOutput("abort_res_data", res_data, 0);
        checkOutput("abort_res_addr", res_addr, 0);
        repeat (12) @(negedge clk);
        applyStimulus(8, 0, 32'h9000, 32'h9100);
        awaitResult(1, r);
        checkOutput("post_abort_result", r, 8);

        // Randomized commands and patterns.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 64; i++) pat[i] = 8'($urandom);
            applyStimulus($urandom_range(0, 40), $urandom_range(0, 3), $urandom, $urandom);
            awaitResult($urandom_range(0, 4), r);
            checkOutput("rand_result", r, m_result);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
